c_requant_unit: RTL and testbench

Downstream output stage of the CFU matmul path. After a MULT command it reads the int32 accumulator rows that the TPU left in global buffer C, one 512-bit row (16 lanes) at a time. Each lane is requantized to int8 with TFLite fixed-point semantics (per-tensor multiplier and shift, output offset, activation clamp). The 16 bytes are packed into one 128-bit beat and handed to the CPU-side response logic through a valid/ready handshake.

---
 rtl/c_requant_unit.sv | 200 ++++++++++++++++++++
 tb/tb_c_requant_unit.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c_requant_unit.sv
// c_requant_unit: reads int32 accumulator rows from buffer C and requantizes
// each of the LANES lanes to int8 (TFLite fixed-point), one packed beat per row.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start, c_base, rows    job launch pulse, first C row, row count (0..2048)
//   q_mult, q_shift        per-tensor multiplier and signed shift (-31..+31)
//   out_offset             output zero point
//   act_min, act_max       signed int8 clamp bounds
//   c_index, c_data_out    C read index (registered) / read data one cycle later
//   out_valid, out_ready   packed beat handshake, out_data = lane 0 in the MSBs
//   busy, done             job active / one-cycle end-of-job pulse
module c_requant_unit #(
    parameter int LANES     = 16,
    parameter int ADDR_BITS = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_BITS-1:0]   c_base,
    input  logic [11:0]            rows,
    input  logic [31:0]            q_mult,
    input  logic [5:0]             q_shift,
    input  logic [31:0]            out_offset,
    input  logic [7:0]             act_min,
    input  logic [7:0]             act_max,
    output logic [ADDR_BITS-1:0]   c_index,
    input  logic [LANES*32-1:0]    c_data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*8-1:0]     out_data,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, LOAD, MUL, RND, PACK, OUT
    } state_t;

    state_t state;

    logic [ADDR_BITS-1:0] base_l;
    logic [11:0]          rows_l;
    logic [11:0]          row_cnt;
    logic [11:0]          row_nxt;
    logic signed [31:0]   mult_l;
    logic signed [31:0]   off_l;
    logic [5:0]           shift_l;
    logic [7:0]           min_l;
    logic [7:0]           max_l;

    logic signed [31:0]   acc  [LANES];
    logic signed [63:0]   prod [LANES];
    logic                 sat  [LANES];
    logic signed [31:0]   yv   [LANES];

    logic signed [31:0]   x_c   [LANES];
    logic signed [63:0]   p_c   [LANES];
    logic                 sat_c [LANES];
    logic signed [63:0]   t_c   [LANES];
    logic signed [63:0]   s_c   [LANES];
    logic signed [31:0]   h_c   [LANES];
    logic signed [31:0]   hs_c  [LANES];
    logic [31:0]          rem_c [LANES];
    logic [31:0]          thr_c [LANES];
    logic signed [31:0]   y_c   [LANES];
    logic signed [31:0]   z_c   [LANES];
    logic [LANES*8-1:0]   pack_c;

    logic [4:0]           rsh;
    logic [31:0]          mask;
    logic signed [31:0]   mn32;
    logic signed [31:0]   mx32;
    logic                 unused_bits;

    assign row_nxt = row_cnt + 12'd1;
    // right-shift amount for negative q_shift: low bits of -q_shift
    assign rsh  = ~shift_l[4:0] + 5'd1;
    assign mask = (32'd1 << rsh) - 32'd1;
    assign mn32 = {{24{min_l[7]}}, min_l};
    assign mx32 = {{24{max_l[7]}}, max_l};

    always_comb begin
        unused_bits = 1'b0;
        pack_c      = '0;
        for (int i = 0; i < LANES; i++) begin
            // shift_l[5] set means a right shift, applied after the multiply
            x_c[i]   = shift_l[5] ? acc[i] : (acc[i] << shift_l[4:0]);
            sat_c[i] = (x_c[i] == 32'sh8000_0000) &&
                       (mult_l == 32'sh8000_0000);
            p_c[i]   = $signed({{32{x_c[i][31]}}, x_c[i]}) *
                       $signed({{32{mult_l[31]}}, mult_l});

            t_c[i]   = prod[i] + (prod[i][63] ? 64'shFFFF_FFFF_C000_0001
                                              : 64'sh0000_0000_4000_0000);
            // bias negatives so the arithmetic shift truncates toward zero
            s_c[i]   = t_c[i][63] ? (t_c[i] + 64'sh0000_0000_7FFF_FFFF)
                                  : t_c[i];
            h_c[i]   = sat[i] ? 32'sh7FFF_FFFF : s_c[i][62:31];

            hs_c[i]  = h_c[i] >>> rsh;
            rem_c[i] = h_c[i] & mask;
            thr_c[i] = (mask >> 1) + {31'd0, h_c[i][31]};
            y_c[i]   = shift_l[5]
                     ? (hs_c[i] + {31'd0, (rem_c[i] > thr_c[i])})
                     : h_c[i];

            z_c[i]   = yv[i] + off_l;
            if (z_c[i] < mn32) begin
                z_c[i] = mn32;
            end else if (z_c[i] > mx32) begin
                z_c[i] = mx32;
            end
            pack_c[(LANES-1-i)*8 +: 8] = z_c[i][7:0];

            unused_bits = unused_bits ^ (^{s_c[i][63], s_c[i][30:0]});
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            base_l  <= c_base;
            rows_l  <= rows;
            mult_l  <= q_mult;
            shift_l <= q_shift;
            off_l   <= out_offset;
            min_l   <= act_min;
            max_l   <= act_max;
        end
        if (state == LOAD) begin
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= c_data_out[(LANES-1-i)*32 +: 32];
            end
        end
        if (state == MUL) begin
            for (int i = 0; i < LANES; i++) begin
                prod[i] <= p_c[i];
                sat[i]  <= sat_c[i];
            end
        end
        if (state == RND) begin
            for (int i = 0; i < LANES; i++) begin
                yv[i] <= y_c[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            c_index   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            row_cnt   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        row_cnt <= '0;
                        if (rows == 12'd0) begin
                            done <= 1'b1;
                        end else begin
                            // address is set up here so it is valid during ISSUE
                            c_index <= c_base;
                            busy    <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= LOAD;
                LOAD:  state <= MUL;
                MUL:   state <= RND;
                RND:   state <= PACK;
                PACK: begin
                    out_data  <= pack_c;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        row_cnt   <= row_nxt;
                        if (row_nxt == rows_l) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            c_index <= base_l + row_nxt[ADDR_BITS-1:0];
                            state   <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c_requant_unit.sv
// tb_c_requant_unit: randomized and directed jobs checked against a
// behavioural requantization model, with a per-cycle protocol checker.
module tb_c_requant_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [10:0]  c_base;
    logic [11:0]  rows;
    logic [31:0]  q_mult;
    logic [5:0]   q_shift;
    logic [31:0]  out_offset;
    logic [7:0]   act_min;
    logic [7:0]   act_max;
    logic [10:0]  c_index;
    logic [511:0] c_data_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;
    int beats    = 0;
    int rdy_mode = 0;

    logic [511:0] mem [2048];

    always #5 clk = ~clk;

    always @(posedge clk) c_data_out <= mem[c_index];

    c_requant_unit dut (
        .clk(clk), .reset(reset), .start(start),
        .c_base(c_base), .rows(rows),
        .q_mult(q_mult), .q_shift(q_shift),
        .out_offset(out_offset),
        .act_min(act_min), .act_max(act_max),
        .c_index(c_index), .c_data_out(c_data_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done)
    );

    task automatic chk(input string nm, input logic [127:0] a,
                       input logic [127:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    task automatic chkb(input string nm, input logic a, input logic e);
        chk(nm, 128'(a), 128'(e));
    endtask

    task automatic chk8(input string nm, input logic [7:0] a,
                        input logic [7:0] e);
        chk(nm, 128'(a), 128'(e));
    endtask

    // Requantize one lane from the arithmetic definition.
    function automatic logic [7:0] rq(input int acc, input int m,
                                      input int sh, input int off,
                                      input int mn, input int mx);
        int     x;
        int     z;
        longint p;
        longint h;
        longint y;
        longint half;
        x = (sh > 0) ? (acc << sh) : acc;
        if (x == int'(32'h8000_0000) && m == int'(32'h8000_0000)) begin
            h = 64'sd2147483647;
        end else begin
            p = longint'(x) * longint'(m);
            if (p >= 0) h = (p + (longint'(1) << 30)) / (longint'(1) << 31);
            else h = (p + 1 - (longint'(1) << 30)) / (longint'(1) << 31);
        end
        // divide by 2^r, round to nearest, ties away from zero
        if (sh < 0) begin
            half = longint'(1) << (-sh - 1);
            if (h >= 0) y = (h + half) >>> (-sh);
            else y = -((-h + half) >>> (-sh));
        end else begin
            y = h;
        end
        z = int'(y) + off;
        if (z < mn) z = mn;
        if (z > mx) z = mx;
        return z[7:0];
    endfunction

    function automatic logic [127:0] beat_of(input logic [511:0] row,
                                             input int m, input int sh,
                                             input int off, input int mn,
                                             input int mx);
        logic [127:0] b;
        logic [31:0]  lane;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            lane = row[(15-i)*32 +: 32];
            b[(15-i)*8 +: 8] = rq(int'(lane), m, sh, off, mn, mx);
        end
        return b;
    endfunction

    logic [127:0] exp_q [$];
    logic [10:0]  addr_q [$];
    logic [127:0] prev_data;
    logic [10:0]  a_tmp;
    bit           rst_prev = 1'b0;
    bit           pend_done = 1'b0;
    bit           hold = 1'b0;
    int           tmr = 0;

    always @(negedge clk) begin
        if (rst_prev) begin
            chk("rst_c_index", 128'(c_index), 128'd0);
            chkb("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_data", out_data, 128'd0);
            chkb("rst_busy", busy, 1'b0);
            chkb("rst_done", done, 1'b0);
        end
        rst_prev = reset;
        if (reset) begin
            exp_q.delete();
            addr_q.delete();
            pend_done = 1'b0;
            hold = 1'b0;
            tmr = 0;
        end else begin
            chkb("done", done, pend_done);
            if (pend_done) chkb("busy_at_done", busy, 1'b0);
            pend_done = 1'b0;
            if (tmr != 0) begin
                if (tmr == 1 && addr_q.size() != 0) begin
                    chk("c_index", 128'(c_index), 128'(addr_q[0]));
                    chkb("busy_in_row", busy, 1'b1);
                end
                if (tmr < 6) chkb("valid_early", out_valid, 1'b0);
                else chkb("valid_at_6", out_valid, 1'b1);
                tmr = (tmr == 6) ? 0 : tmr + 1;
            end
            if (hold) begin
                chkb("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, prev_data);
            end
            hold = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid) chkb("valid_has_row", exp_q.size() != 0, 1'b1);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                chk("beat", out_data, exp_q[0]);
                void'(exp_q.pop_front());
                void'(addr_q.pop_front());
                beats++;
                if (exp_q.size() == 0) pend_done = 1'b1;
                else tmr = 1;
            end
            if (start && !busy) begin
                for (int k = 0; k < int'(rows); k++) begin
                    a_tmp = c_base + 11'(k);
                    addr_q.push_back(a_tmp);
                    exp_q.push_back(beat_of(mem[a_tmp],
                        int'($signed(q_mult)), int'($signed(q_shift)),
                        int'($signed(out_offset)),
                        int'($signed(act_min)), int'($signed(act_max))));
                end
                if (rows == 12'd0) pend_done = 1'b1;
                else tmr = 1;
            end
        end
    end

    int nhs  = 0;
    int lows = 0;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_mode != 2) begin
                nhs = 0;
                lows = 0;
            end else if (out_valid && out_ready) begin
                nhs++;
            end
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                out_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else if (out_valid && nhs == 1 && lows < 4) begin
                out_ready = 1'b0;
                lows++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic launch(input logic [10:0] b, input int n,
                          input logic [31:0] m, input int sh,
                          input int off, input int mn, input int mx);
        @(posedge clk);
        #1;
        c_base = b;
        rows = 12'(n);
        q_mult = m;
        q_shift = 6'(sh);
        out_offset = 32'(off);
        act_min = 8'(mn);
        act_max = 8'(mx);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c_base = 11'($urandom);
        rows = 12'($urandom);
        q_mult = $urandom;
        q_shift = 6'($urandom);
        out_offset = $urandom;
        act_min = 8'($urandom);
        act_max = 8'($urandom);
    endtask

    task automatic wait_idle(input int b0, input int n);
        int i;
        for (i = 0; i < 400 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        chkb("idle_timeout", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("drain", 128'(exp_q.size()), 128'd0);
        chk("beat_count", 128'(beats - b0), 128'(n));
    endtask

    task automatic wait_beat(output logic [127:0] d);
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chkb("beat_wait", out_valid, 1'b1);
        d = out_data;
    endtask

    logic [127:0] d;
    logic [127:0] bb;
    logic [511:0] row;
    int b0;
    int n;
    int mn;
    int mx;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        c_base = '0;
        rows = '0;
        q_mult = '0;
        q_shift = '0;
        out_offset = '0;
        act_min = '0;
        act_max = '0;
        for (int r = 0; r < 2048; r++) begin
            for (int l = 0; l < 16; l++) begin
                if ($urandom_range(0, 3) == 0) mem[r][(15-l)*32 +: 32] = $urandom;
                else mem[r][(15-l)*32 +: 32] = $urandom_range(0, 4000) - 2000;
            end
        end
        for (int l = 0; l < 16; l++) mem[0][(15-l)*32 +: 32] = 32'(2 * l);
        mem[5][511:480] = 32'd1000;
        mem[5][479:448] = -32'sd1000;
        mem[6][511:480] = 32'h8000_0000;
        mem[7][511:480] = 32'd20;
        mem[7][479:448] = -32'sd20;
        mem[7][447:416] = 32'd5;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk8("m_rshift_pos", rq(20, 32'h4000_0000, -2, 5, -128, 127), 8'h08);
        chk8("m_rshift_neg", rq(-20, 32'h4000_0000, -2, 5, -128, 127), 8'h02);
        chk8("m_lshift", rq(5, 32'h4000_0000, 3, 0, -128, 127), 8'h14);
        chk8("m_clamp_hi", rq(1000, 32'h7FFF_FFFF, 0, 0, -128, 127), 8'h7F);
        chk8("m_clamp_lo", rq(-1000, 32'h7FFF_FFFF, 0, 0, -128, 127), 8'h80);
        chk8("m_sat", rq(int'(32'h8000_0000), int'(32'h8000_0000), 0, 0,
                         -128, 127), 8'h7F);
        bb = beat_of(mem[0], 32'h4000_0000, 0, 0, -128, 127);
        chk("m_basic", bb, 128'h000102030405060708090A0B0C0D0E0F);

        b0 = beats;
        launch(11'd0, 1, 32'h4000_0000, 0, 0, -128, 127);
        chkb("t1_busy", busy, 1'b1);
        chk("t1_c_index", 128'(c_index), 128'd0);
        wait_beat(d);
        chk("t1_beat", d, 128'h000102030405060708090A0B0C0D0E0F);
        wait_idle(b0, 1);

        b0 = beats;
        launch(11'd5, 1, 32'h7FFF_FFFF, 0, 0, -128, 127);
        wait_beat(d);
        chk8("t2_hi", d[127:120], 8'h7F);
        chk8("t2_lo", d[119:112], 8'h80);
        wait_idle(b0, 1);

        b0 = beats;
        launch(11'd5, 1, 32'h7FFF_FFFF, 0, 0, -100, 100);
        wait_beat(d);
        chk8("t3_hi", d[127:120], 8'h64);
        chk8("t3_lo", d[119:112], 8'h9C);
        wait_idle(b0, 1);

        b0 = beats;
        launch(11'd6, 1, 32'h8000_0000, 0, 0, -128, 127);
        wait_beat(d);
        chk8("t4_sat", d[127:120], 8'h7F);
        wait_idle(b0, 1);

        b0 = beats;
        launch(11'd7, 1, 32'h4000_0000, -2, 5, -128, 127);
        wait_beat(d);
        chk8("t5_pos", d[127:120], 8'h08);
        chk8("t5_neg", d[119:112], 8'h02);
        wait_idle(b0, 1);

        b0 = beats;
        launch(11'd7, 1, 32'h4000_0000, 3, 0, -128, 127);
        wait_beat(d);
        chk8("t6_lshift", d[111:104], 8'h14);
        wait_idle(b0, 1);

        rdy_mode = 2;
        b0 = beats;
        launch(11'h7FE, 3, 32'h4000_0000, -1, 3, -128, 127);
        chk("t7_c_index", 128'(c_index), 128'h7FE);
        wait_idle(b0, 3);
        rdy_mode = 0;

        b0 = beats;
        launch(11'd9, 0, 32'h4000_0000, 0, 0, -128, 127);
        chkb("t8_busy", busy, 1'b0);
        chkb("t8_valid", out_valid, 1'b0);
        wait_idle(b0, 0);

        b0 = beats;
        launch(11'd20, 2, 32'h5000_0000, -4, -7, -90, 90);
        @(posedge clk);
        #1;
        c_base = 11'd300;
        rows = 12'd5;
        q_mult = 32'h7000_0000;
        q_shift = 6'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(b0, 2);

        b0 = beats;
        launch(11'd40, 4, 32'h4000_0000, 0, 0, -128, 127);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t10_beats", 128'(beats - b0), 128'd1);
        chkb("t10_busy", busy, 1'b0);

        b0 = beats;
        launch(11'd41, 2, 32'h4000_0000, 0, 0, -128, 127);
        wait_idle(b0, 2);

        rdy_mode = 1;
        for (int j = 0; j < 14; j++) begin
            n  = $urandom_range(1, 6);
            mn = $urandom_range(0, 255) - 128;
            mx = $urandom_range(mn + 128, 255) - 128;
            case ($urandom_range(0, 3))
                0: d[31:0] = $urandom;
                1: d[31:0] = 32'h4000_0000;
                2: d[31:0] = 32'h8000_0000;
                default: d[31:0] = $urandom_range(32'h2000_0000, 32'h7FFF_FFFF);
            endcase
            b0 = beats;
            launch(11'($urandom), n, d[31:0], $urandom_range(0, 62) - 31,
                   $urandom_range(0, 200) - 100, mn, mx);
            wait_idle(b0, n);
        end
        rdy_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
